// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared constants for the load/store unit: default widths, the write-enable
// level, request size encodings and the FSM state encoding.
// No ports.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic WRITE_ENABLE = 1'b1;

    // Request size encodings; 2'b11 is folded onto word by the LSU.
    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        LSU_ST_IDLE   = 3'd0,
        LSU_ST_LOAD   = 3'd1,
        LSU_ST_RMW_RD = 3'd2,
        LSU_ST_WRITE  = 3'd3,
        LSU_ST_RESP   = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Combinational lane logic for a 32-bit data port.
//   size_i       : access size (LSU_SIZE_B/H/W, 2'b11 behaves as word)
//   unsigned_i   : 1 = zero-extend loads, 0 = sign-extend
//   addr_lo_i    : byte offset within the word
//   rdata_i      : word read from RAM
//   wdata_i      : right-aligned store data
//   load_data_o  : selected lane, extended to 32 bits
//   merge_data_o : rdata_i with the store lane replaced by wdata_i
// Halfwords use addr_lo_i[1] only; addr_lo_i[0] is ignored for them.
// -----------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_b;
    logic        sign_h;

    always_comb begin
        lane_b = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_b = ~unsigned_i & lane_b[7];
        sign_h = ~unsigned_i & lane_h[15];

        case (size_i)
            LSU_SIZE_B: load_data_o = {{24{sign_b}}, lane_b};
            LSU_SIZE_H: load_data_o = {{16{sign_h}}, lane_h};
            default:    load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        merge_data_o = rdata_i;
        case (size_i)
            LSU_SIZE_B: begin
                case (addr_lo_i)
                    2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_data_o[23:16] = wdata_i[7:0];
                    default: merge_data_o[31:24] = wdata_i[7:0];
                endcase
            end
            LSU_SIZE_H: begin
                if (addr_lo_i[1]) begin
                    merge_data_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_data_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit driving a word-wide RAM port (combinational read, posedge
// write). Byte/half/word loads with sign/zero extension; sub-word stores are
// done as read-modify-write since the RAM only writes whole words.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             extended load data (0 for stores)
//   rsp_err_o               misaligned access (only with LSU_MISALIGN_TRAP_EN)
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i   RAM port
//   dbg_state_o             current FSM state
//
// Handshake: a request transfers on a rising clk_i edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE (and low during
// reset); requests are never queued and responses cannot be stalled.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, a misaligned
// half/word request skips the RAM and responds next cycle with rsp_err_o=1.
// When undefined, offending low address bits are ignored.
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output lsu_state_e        dbg_state_o
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;

    logic [1:0]        size_n;
    logic              accept;
    logic              misalign;

    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    // Merge register: only updated on the edge entering WRITE, so the RAM
    // write data holds its last value in every other state.
    logic [DATA_W-1:0] mem_wdata_q;

    logic [31:0]       lane_load;
    logic [31:0]       lane_merge;

    assign size_n = (req_size_i == 2'b11) ? LSU_SIZE_W : req_size_i;
    assign accept = req_valid_i && (state_q == LSU_ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;

    assign misalign = ((size_n == LSU_SIZE_H) && req_addr_i[0]) ||
                      ((size_n == LSU_SIZE_W) && (req_addr_i[1:0] != 2'b00));
    assign rsp_err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misalign;
        end
    end
`else
    assign misalign  = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LSU_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (req_valid_i) begin
                    if (misalign) begin
                        state_d = LSU_ST_RESP;
                    end else if (!req_we_i) begin
                        state_d = LSU_ST_LOAD;
                    end else if (size_n == LSU_SIZE_W) begin
                        state_d = LSU_ST_WRITE;
                    end else begin
                        state_d = LSU_ST_RMW_RD;
                    end
                end
            end
            LSU_ST_LOAD:   state_d = LSU_ST_RESP;
            LSU_ST_RMW_RD: state_d = LSU_ST_WRITE;
            LSU_ST_WRITE:  state_d = LSU_ST_RESP;
            LSU_ST_RESP:   state_d = LSU_ST_IDLE;
            default:       state_d = LSU_ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_q      <= LSU_SIZE_B;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                LSU_ST_IDLE: begin
                    if (accept) begin
                        size_q    <= size_n;
                        uns_q     <= req_unsigned_i;
                        addr_lo_q <= req_addr_i[1:0];
                        wdata_q   <= req_wdata_i;
                        rdata_q   <= '0;
                        // A trapped access must not disturb the RAM port.
                        if (!misalign) begin
                            mem_addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            if (req_we_i && (size_n == LSU_SIZE_W)) begin
                                mem_wdata_q <= req_wdata_i;
                            end
                        end
                    end
                end
                LSU_ST_LOAD:   rdata_q     <= lane_load;
                LSU_ST_RMW_RD: mem_wdata_q <= lane_merge;
                default: ;
            endcase
        end
    end

    lsu_lane u_lane (
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .addr_lo_i    (addr_lo_q),
        .rdata_i      (mem_rdata_i),
        .wdata_i      (wdata_q),
        .load_data_o  (lane_load),
        .merge_data_o (lane_merge)
    );

    // mem_we_o is pure state decode, so it drops as soon as rst_i rises.
    assign mem_we_o    = (state_q == LSU_ST_WRITE) ? WRITE_ENABLE : ~WRITE_ENABLE;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign req_ready_o = (state_q == LSU_ST_IDLE) && !rst_i;
    assign rsp_valid_o = (state_q == LSU_ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Testbench for lsu with a behavioural 64-word RAM, an expected-response queue
// and a scenario task per feature.
// -----------------------------------------------------------------------------
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    lsu_state_e  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    logic [31:0] ram [0:63];
    logic [32:0] exp_q[$];  // {err, rdata}

    lsu dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .dbg_state_o    (dbg_state)
    );

    // Clock / RAM
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr[7:2]] = mem_wdata;
            wr_cnt++;
        end
    end

    // Scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%08h, none expected", rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model
    function automatic logic [31:0] ld_ref(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [31:0] s;
        if (sz == 2'b00) begin
            s = w >> (8 * a[1:0]);
            return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        end else if (sz == 2'b01) begin
            s = w >> (16 * a[1]);
            return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        end
        return w;
    endfunction

    function automatic logic [31:0] st_ref(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * a[1:0];
            mask = 32'h0000_00FF << sh;
        end else if (sz == 2'b01) begin
            sh = 16 * a[1];
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // Driver: one request, then watch six cycles. lat = first cycle after the
    // accept edge with rsp_valid high (-1 if none); rdy_seen = req_ready high
    // before the response.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic rdy_seen);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = -1;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && lat < 0) lat = k;
            if (lat < 0 && req_ready === 1'b1) rdy_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, mem_we, req_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid/err/we/ready=%04b, expected 0000",
                     {rsp_valid, rsp_err, mem_we, req_ready});
        end
        n_checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%08h addr=%08h wdata=%08h, expected all 0",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        n_checks++;
        if (dbg_state !== LSU_ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected %0d", dbg_state, LSU_ST_IDLE);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b, expected 1", req_ready);
        end
    endtask

    task automatic test_load();
        int lat;
        logic rs;
        logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [4]  = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] ex [4]  = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h8899_AABB};
        ram[4] = 32'h8899_AABB;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, ex[i]});
            issue(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rs);
            n_checks++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL load_latency[%0d]: got %0d, expected 2", i, lat);
            end
        end
    endtask

    task automatic test_store_sub();
        int lat;
        logic rs;
        int w0;
        ram[8] = 32'h1122_3344;
        w0 = wr_cnt;
        exp_q.push_back(33'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00EE, lat, rs);
        n_checks++;
        if (lat != 3 || wr_cnt != w0 + 1) begin
            n_fail++;
            $display("FAIL store_byte_timing: got lat=%0d writes=%0d, expected lat=3 writes=1", lat, wr_cnt - w0);
        end
        n_checks++;
        if (ram[8] !== 32'h1122_EE44) begin
            n_fail++;
            $display("FAIL store_byte_data: got %08h, expected 1122ee44", ram[8]);
        end
        exp_q.push_back(33'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, lat, rs);
        n_checks++;
        if (ram[8] !== 32'hBEEF_EE44 || lat != 3) begin
            n_fail++;
            $display("FAIL store_half: got %08h lat=%0d, expected beefee44 lat=3", ram[8], lat);
        end
    endtask

    task automatic test_store_word();
        int lat;
        logic rs;
        int w0;
        ram[12] = 32'h0;
        w0 = wr_cnt;
        exp_q.push_back(33'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF, lat, rs);
        n_checks++;
        if (lat != 2 || rs !== 1'b0 || wr_cnt != w0 + 1) begin
            n_fail++;
            $display("FAIL store_word_timing: got lat=%0d ready_seen=%0b writes=%0d, expected 2/0/1",
                     lat, rs, wr_cnt - w0);
        end
        n_checks++;
        if (ram[12] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL store_word_data: got %08h, expected deadbeef", ram[12]);
        end
    endtask

    task automatic test_reset_midop();
        int w0;
        ram[20] = 32'hCAFE_F00D;
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'b00;
        req_addr = 32'h51;
        req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (dbg_state !== LSU_ST_RMW_RD) begin
            n_fail++;
            $display("FAIL midop_state: got %0d, expected %0d", dbg_state, LSU_ST_RMW_RD);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_err, mem_we, req_ready} !== 4'b0000 ||
            {rsp_rdata, mem_addr, mem_wdata} !== 96'h0 || dbg_state !== LSU_ST_IDLE) begin
            n_fail++;
            $display("FAIL midop_outputs: got ctrl=%04b addr=%08h wdata=%08h state=%0d, expected zeros/IDLE",
                     {rsp_valid, rsp_err, mem_we, req_ready}, mem_addr, mem_wdata, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (ram[20] !== 32'hCAFE_F00D || wr_cnt != w0 || dbg_state !== LSU_ST_IDLE) begin
            n_fail++;
            $display("FAIL midop_nowrite: got ram=%08h writes=%0d state=%0d, expected cafef00d/0/IDLE",
                     ram[20], wr_cnt - w0, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n;
        int acc [2];
        logic both;
        ram[4] = 32'h8899_AABB;
        exp_q.push_back({1'b0, 32'h8899_AABB});
        exp_q.push_back({1'b0, 32'h8899_AABB});
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'b10;
        req_addr = 32'h10;
        n = 0;
        both = 1'b0;
        acc[0] = 0;
        acc[1] = 0;
        for (cyc = 0; cyc < 12; cyc++) begin
            if (rsp_valid === 1'b1 && req_ready === 1'b1) both = 1'b1;
            if (req_valid && req_ready === 1'b1 && n < 2) begin
                acc[n] = cyc;
                n++;
                if (n == 2) begin
                    @(posedge clk);
                    #1;
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if (n != 2 || acc[1] - acc[0] != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got accepts=%0d spacing=%0d, expected 2 and 3", n, acc[1] - acc[0]);
        end
        n_checks++;
        if (both !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_in_resp: got ready high with rsp_valid, expected never");
        end
    endtask

    task automatic test_misalign();
        int lat;
        logic rs;
        int w0;
        logic [31:0] a0;
        ram[16] = 32'h0BAD_CAFE;
        w0 = wr_cnt;
        a0 = mem_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_q.push_back({1'b1, 32'h0});
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rs);
        n_checks++;
        if (lat != 1 || mem_addr !== a0 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL misalign_trap: got lat=%0d addr=%08h writes=%0d, expected 1/%08h/0",
                     lat, mem_addr, wr_cnt - w0, a0);
        end
`else
        exp_q.push_back({1'b0, 32'h0BAD_CAFE});
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rs);
        n_checks++;
        if (lat != 2 || mem_addr !== 32'h40 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL misalign_ignore: got lat=%0d addr=%08h writes=%0d, expected 2/00000040/0 (was %08h)",
                     lat, mem_addr, wr_cnt - w0, a0);
        end
`endif
    endtask

    task automatic test_random();
        int lat;
        logic rs;
        logic        we;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] nw;
        int exp_lat;
        for (int i = 32; i < 64; i++) ram[i] = $urandom;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(128, 255));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            d  = $urandom;
            if (we) begin
                nw = st_ref(ram[a[7:2]], sz, a, d);
                exp_q.push_back(33'h0);
                exp_lat = sz[1] ? 2 : 3;
            end else begin
                nw = ram[a[7:2]];
                exp_q.push_back({1'b0, ld_ref(ram[a[7:2]], sz, un, a)});
                exp_lat = 2;
            end
            issue(we, sz, un, a, d, lat, rs);
            n_checks++;
            if (lat != exp_lat || ram[a[7:2]] !== nw) begin
                n_fail++;
                $display("FAIL random[%0d]: we=%0b sz=%0d addr=%02h got lat=%0d ram=%08h, expected lat=%0d ram=%08h",
                         i, we, sz, a[7:0], lat, ram[a[7:2]], exp_lat, nw);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        test_reset();
        test_load();
        test_store_sub();
        test_store_word();
        test_reset_midop();
        test_back_to_back();
        test_misalign();
        test_random();
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_missing: got %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
